openfire_prefetch: RTL

Instruction prefetch unit feeding the DECODE stage. It issues sequential word reads to instruction memory over a req/ack handshake and buffers returned words in a small queue. Each queued word is presented to DECODE as `instruction` with its `pc_decode`. It redirects to the branch target on a pipeline flush and requests a pipeline stall when it has no instruction ready.

---
 rtl/openfire_prefetch_pkg.sv | 5 +
 rtl/openfire_prefetch_fifo.sv | 43 ++++
 rtl/openfire_prefetch.sv | 76 +++++++
 3 files changed

// File: rtl/openfire_prefetch_pkg.sv
// openfire_prefetch_pkg: shared constants for the instruction prefetch unit
package openfire_prefetch_pkg;
  localparam int A_SPACE = 16;
  localparam logic [31:0] NOP_INSTR = 32'h8000_0000;
endpackage

// File: rtl/openfire_prefetch_fifo.sv
// openfire_prefetch_fifo: synchronous FIFO with clear and asynchronous-read head
module openfire_prefetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  // pointer and occupancy update; clear realigns the read pointer onto the write pointer
  always_comb begin
    rd_d  = clear ? wr_q : rd_q + AW'(pop);
    wr_d  = clear ? wr_q : wr_q + AW'(push);
    cnt_d = clear ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // pointer and count registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: only counted entries are ever presented as valid
  always_ff @(posedge clock) begin
    if (push && !clear) mem_q[wr_q] <= din;
  end
  assign head  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/openfire_prefetch.sv
// openfire_prefetch: sequential instruction prefetch with flush redirect feeding DECODE
module openfire_prefetch
  import openfire_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W = A_SPACE + 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] branch_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instruction,
  output logic [PC_W-1:0] pc_decode,
  output logic            fetch_empty
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic            pending_q, pending_d, discard_q, discard_d;
  logic [PC_W-1:0] addr_q, addr_d, fetch_pc_q, fetch_pc_d, last_pc_q, last_pc_d;
  logic [PC_W-1:0] target, head_pc;
  logic [31:0]     head_word;
  logic [PC_W+31:0] head;
  logic [CW-1:0]   count;
  logic            flush_v, ack_v, issue, push, pop;
  // request/discard control; a flush overrides any ack or pop in the same cycle
  always_comb begin
    flush_v    = flush & ~stall;
    ack_v      = imem_ack & pending_q;
    target     = branch_target & ~PC_W'(3);
    issue      = ~pending_q & (flush_v | (count < CW'(DEPTH)));
    push       = ack_v & ~discard_q & ~flush_v;
    pop        = ~stall & ~flush_v & (count != '0);
    pending_d  = issue | (pending_q & ~ack_v);
    addr_d     = issue ? (flush_v ? target : fetch_pc_q) : addr_q;
    fetch_pc_d = flush_v ? target : push ? fetch_pc_q + PC_W'(4) : fetch_pc_q;
    discard_d  = (flush_v ? pending_q : discard_q) & ~ack_v;
    last_pc_d  = pop ? head_pc : last_pc_q;
  end
  // request, address and pc registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
      addr_q     <= '0;
      fetch_pc_q <= '0;
      last_pc_q  <= '0;
    end else begin
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      last_pc_q  <= last_pc_d;
    end
  end
  openfire_prefetch_fifo #(.W(PC_W + 32), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (flush_v),
    .din   ({addr_q, imem_data}),
    .head  (head),
    .count (count)
  );
  assign head_pc     = head[PC_W+31:32];
  assign head_word   = head[31:0];
  assign imem_req    = pending_q;
  assign imem_addr   = addr_q;
  assign fetch_empty = (count == '0);
  assign instruction = fetch_empty ? NOP_INSTR : head_word;
  assign pc_decode   = fetch_empty ? last_pc_q : head_pc;
endmodule
